comp_mult_apb_seq: RTL

Synthesizable APB master that programs and supervises the comp_mult_top register file without CPU involvement. Jobs are queued in an internal FIFO; each job is one descriptor {op1 base, op2 base, result base, op count}. For each job the block issues the full configure/start/poll/clear/status sequence and returns a completion record. It sits between a host job source and the comp_mult_top APB slave port.

---
 rtl/comp_mult_pkg.sv | 34 +++
 rtl/comp_mult_job_fifo.sv | 56 +++++
 rtl/comp_mult_apb_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_mult_pkg.sv
// Shared constants for the comp_mult APB sequencer: register map, config codes,
// completion error codes, FSM encoding and step indices.
package comp_mult_pkg;

  localparam logic [2:0] OFS_OP1  = 3'd0;
  localparam logic [2:0] OFS_OP2  = 3'd1;
  localparam logic [2:0] OFS_RES  = 3'd2;
  localparam logic [2:0] OFS_NR   = 3'd3;
  localparam logic [2:0] OFS_CFG  = 3'd4;
  localparam logic [2:0] OFS_STOP = 3'd5;
  localparam logic [2:0] OFS_STS  = 3'd6;

  localparam logic [15:0] CFG_START = 16'h0001;
  localparam logic [15:0] CFG_SWRST = 16'h0002;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  // Step 0 doubles as the timeout cleanup write (engine sw reset).
  localparam logic [3:0] STEP_RST  = 4'd0;
  localparam logic [3:0] STEP_POLL = 4'd6;
  localparam logic [3:0] STEP_CLR  = 4'd7;
  localparam logic [3:0] STEP_STS  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/comp_mult_job_fifo.sv
// Synchronous job FIFO with valid/ready on both sides; DEPTH must be a power of 2
// so the pointers wrap naturally.
module comp_mult_job_fifo #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DWIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push, pop;

  assign in_rdy   = (cnt_q != CW'(DEPTH));
  assign out_val  = (cnt_q != '0);
  assign out_data = mem_q[rd_ptr_q];
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/comp_mult_apb_seq.sv
// APB master that runs queued comp_mult jobs: configure, start, poll stop bit,
// clear, read status, and hand back a completion record.
module comp_mult_apb_seq
  import comp_mult_pkg::*;
#(
  parameter int APB_BADDR     = 1024,
  parameter int SYS_AW        = 16,
  parameter int REG_DW        = 16,
  parameter int JOB_DEPTH     = 4,
  parameter int POLL_INTERVAL = 5,
  parameter int POLL_MAX      = 1024
) (
  input  logic                clk,
  input  logic                sw_rst,
  input  logic                job_val,
  output logic                job_rdy,
  input  logic [4*REG_DW-1:0] job_data,
  output logic                done_val,
  input  logic                done_rdy,
  output logic [REG_DW+1:0]   done_data,
  output logic                busy,
  output logic [SYS_AW-1:0]   apb_paddr,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [REG_DW-1:0]   apb_pwdata,
  input  logic                apb_pready,
  input  logic [REG_DW-1:0]   apb_prdata,
  input  logic                apb_pslverr
);

  localparam int JW = 4 * REG_DW;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int IW = $clog2(POLL_INTERVAL + 1);

  logic              fifo_val, fifo_pop, launch;
  logic [JW-1:0]     fifo_data;
  state_e            state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [SYS_AW-1:0] paddr_q, paddr_d;
  logic [REG_DW-1:0] pwdata_q, pwdata_d;
  logic              done_val_q, done_val_d;
  logic [REG_DW+1:0] done_data_q, done_data_d;
  logic [JW-1:0]     job_q, job_d;
  logic [3:0]        step_q, step_d;
  logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
  logic [IW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              tmo_q, tmo_d;

  comp_mult_job_fifo #(.DWIDTH(JW), .DEPTH(JOB_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (sw_rst),
    .in_val   (job_val),
    .in_rdy   (job_rdy),
    .in_data  (job_data),
    .out_val  (fifo_val),
    .out_rdy  (fifo_pop),
    .out_data (fifo_data)
  );

  function automatic logic [2:0] step_ofs(input logic [3:0] s);
    case (s)
      4'd0, 4'd5: return OFS_CFG;
      4'd1:       return OFS_OP1;
      4'd2:       return OFS_OP2;
      4'd3:       return OFS_RES;
      4'd4:       return OFS_NR;
      4'd6, 4'd7: return OFS_STOP;
      default:    return OFS_STS;
    endcase
  endfunction

  function automatic logic step_wr(input logic [3:0] s);
    return !(s == STEP_POLL || s == STEP_STS);
  endfunction

  function automatic logic [REG_DW-1:0] step_wdata(input logic [3:0] s, input logic [JW-1:0] j);
    case (s)
      4'd0:    return REG_DW'(CFG_SWRST);
      4'd1:    return j[4*REG_DW-1 -: REG_DW];
      4'd2:    return j[3*REG_DW-1 -: REG_DW];
      4'd3:    return j[2*REG_DW-1 -: REG_DW];
      4'd4:    return j[REG_DW-1:0];
      4'd5:    return REG_DW'(CFG_START);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    done_val_d  = done_val_q;
    done_data_d = done_data_q;
    job_d       = job_q;
    step_d      = step_q;
    poll_cnt_d  = poll_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    launch      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_val) begin
          fifo_pop   = 1'b1;
          job_d      = fifo_data;
          step_d     = STEP_RST;
          poll_cnt_d = '0;
          tmo_d      = 1'b0;
          launch     = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready) begin
          // Every transfer is followed by at least one idle bus cycle in WAIT.
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
          if (apb_pslverr) begin
            done_val_d  = 1'b1;
            done_data_d = {ERR_SLV, {REG_DW{1'b0}}};
            state_d     = ST_REPORT;
          end else if (tmo_q) begin
            done_val_d  = 1'b1;
            done_data_d = {ERR_TMO, {REG_DW{1'b0}}};
            state_d     = ST_REPORT;
          end else if (step_q == STEP_POLL) begin
            if (apb_prdata[0]) begin
              step_d = STEP_CLR;
            end else begin
              poll_cnt_d = poll_cnt_q + PW'(1);
              if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                tmo_d  = 1'b1;
                step_d = STEP_RST;
              end else begin
                wait_cnt_d = IW'(POLL_INTERVAL - 1);
              end
            end
          end else if (step_q == STEP_STS) begin
            done_val_d  = 1'b1;
            done_data_d = {ERR_OK, apb_prdata};
            state_d     = ST_REPORT;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          launch  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          wait_cnt_d = wait_cnt_q - IW'(1);
        end
      end
      ST_REPORT: begin
        if (done_rdy) begin
          done_val_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = SYS_AW'(APB_BADDR) + SYS_AW'(step_ofs(step_d));
      pwrite_d  = step_wr(step_d);
      pwdata_d  = step_wr(step_d) ? step_wdata(step_d, job_d) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      done_val_q  <= 1'b0;
      done_data_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      done_val_q  <= done_val_d;
      done_data_q <= done_data_d;
    end
  end

  // Job context is always reloaded in IDLE before use, so it needs no reset.
  always_ff @(posedge clk) begin
    job_q      <= job_d;
    step_q     <= step_d;
    poll_cnt_q <= poll_cnt_d;
    wait_cnt_q <= wait_cnt_d;
    tmo_q      <= tmo_d;
  end

  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign done_val    = done_val_q;
  assign done_data   = done_data_q;
  assign busy        = (state_q != ST_IDLE) || fifo_val;

endmodule
